// File: rtl/ltsm_pkg.sv
// rtl/ltsm_pkg.sv - shared state and pin-mux encodings for the LTSM sequencer
package ltsm_pkg;

    typedef enum logic [2:0] {
        LT_TRAINERROR = 3'd0,
        LT_RESET      = 3'd1,
        LT_SBINIT     = 3'd2,
        LT_MBINIT     = 3'd3,
        LT_MBTRAIN    = 3'd4,
        LT_LINKINIT   = 3'd5,
        LT_L1_L2      = 3'd6,
        LT_ACTIVE     = 3'd7
    } LT_state_t;

    typedef enum logic [1:0] {
        SB_Z        = 2'd0,
        SB_DISABLED = 2'd1,
        SB_SBINIT   = 2'd2,
        SB_COMS     = 2'd3
    } SB_mux_sel_t;

    typedef enum logic [2:0] {
        MB_Z        = 3'd0,
        MB_DISABLED = 3'd1,
        MB_MBINIT   = 3'd2,
        MB_COMS     = 3'd3,
        MB_MBTRAIN  = 3'd4
    } MB_mux_sel_t;

    function automatic logic is_training(input LT_state_t s);
        return (s == LT_SBINIT) || (s == LT_MBINIT) || (s == LT_MBTRAIN) || (s == LT_LINKINIT);
    endfunction

endpackage

// File: rtl/ltsm_timer.sv
// rtl/ltsm_timer.sv - clearable up-counter that saturates at its terminal count
module ltsm_timer #(
    parameter int unsigned COUNT = 16,
    parameter int unsigned W     = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam logic [W-1:0] TC_VAL = W'(COUNT - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tc_o = (cnt_q == TC_VAL);

    // Holding at the terminal count keeps tc_o stable instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !tc_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ltsm_ctrl.sv
// rtl/ltsm_ctrl.sv - UCIe link-training state machine sequencer
module ltsm_ctrl
    import ltsm_pkg::*;
#(
    parameter int unsigned RESET_CYCLES    = 400000,
    parameter int unsigned TIMEOUT_CYCLES  = 800000,
    parameter int unsigned ERR_HOLD_CYCLES = 16,
    parameter int unsigned MAX_RETRY       = 3,
    parameter int unsigned CNT_W           = 20
) (
    input  logic                           clk_100MHz,
    input  logic                           reset_n,
    input  logic                           enable_i,
    input  logic                           start_lt_i,
    input  logic                           retrain_req_i,
    input  logic                           lp_req_i,
    input  logic                           sbinit_done_i,
    input  logic                           mbinit_done_i,
    input  logic                           mbtrain_done_i,
    input  logic                           linkinit_done_i,
    input  logic                           sbinit_err_i,
    input  logic                           mbinit_err_i,
    input  logic                           mbtrain_err_i,
    input  logic                           linkinit_err_i,
    output logic                           sbinit_en_o,
    output logic                           mbinit_en_o,
    output logic                           mbtrain_en_o,
    output logic                           linkinit_en_o,
    output logic [2:0]                     state_o,
    output logic [1:0]                     sb_sel_o,
    output logic [2:0]                     mb_sel_o,
    output logic                           link_up_o,
    output logic                           link_fail_o,
    output logic [$clog2(MAX_RETRY+1)-1:0] retry_cnt_o
);

    localparam int RW     = $clog2(MAX_RETRY + 1);
    localparam int HOLD_W = $clog2(ERR_HOLD_CYCLES + 1);

    LT_state_t         state_q, state_d;
    logic              dwell_done_q, dwell_done_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic              link_fail_q, link_fail_d;

    logic state_chg, dwell_tc, dwell_done, tmo, hold_done;

    ltsm_timer #(.COUNT(RESET_CYCLES), .W(CNT_W)) u_dwell (
        .clk   (clk_100MHz),
        .rst_n (reset_n),
        .clr_i (state_chg),
        .en_i  (state_q == LT_RESET),
        .tc_o  (dwell_tc)
    );

    ltsm_timer #(.COUNT(TIMEOUT_CYCLES), .W(CNT_W)) u_timeout (
        .clk   (clk_100MHz),
        .rst_n (reset_n),
        .clr_i (state_chg),
        .en_i  (is_training(state_q)),
        .tc_o  (tmo)
    );

    // Terminal count is used directly so RESET lasts exactly RESET_CYCLES cycles.
    assign dwell_done = dwell_done_q | dwell_tc;
    assign hold_done  = (hold_q == HOLD_W'(ERR_HOLD_CYCLES - 1));
    assign state_chg  = (state_d != state_q);

    function automatic LT_state_t train_next(input LT_state_t cur, input logic err,
                                             input logic done, input logic timeout,
                                             input LT_state_t nxt);
        if (err || timeout) return LT_TRAINERROR;
        if (done)           return nxt;
        return cur;
    endfunction

    always_comb begin
        state_d = state_q;
        case (state_q)
            LT_RESET:
                if (dwell_done && start_lt_i && !link_fail_q) state_d = LT_SBINIT;
            LT_SBINIT:   state_d = train_next(state_q, sbinit_err_i, sbinit_done_i, tmo, LT_MBINIT);
            LT_MBINIT:   state_d = train_next(state_q, mbinit_err_i, mbinit_done_i, tmo, LT_MBTRAIN);
            LT_MBTRAIN:  state_d = train_next(state_q, mbtrain_err_i, mbtrain_done_i, tmo, LT_LINKINIT);
            LT_LINKINIT: state_d = train_next(state_q, linkinit_err_i, linkinit_done_i, tmo, LT_ACTIVE);
            LT_ACTIVE:
                if (retrain_req_i)  state_d = LT_MBTRAIN;
                else if (lp_req_i)  state_d = LT_L1_L2;
            LT_L1_L2:
                if (!lp_req_i)      state_d = LT_MBTRAIN;
            LT_TRAINERROR:
                if (hold_done)      state_d = LT_RESET;
            default:                state_d = LT_RESET;
        endcase
        if (!enable_i) state_d = LT_RESET;
    end

    always_comb begin
        dwell_done_d = state_chg ? 1'b0 : (dwell_done_q | ((state_q == LT_RESET) & dwell_tc));

        hold_d = hold_q;
        if (state_chg) begin
            hold_d = '0;
        end else if ((state_q == LT_TRAINERROR) && !hold_done) begin
            hold_d = hold_q + 1'b1;
        end

        retry_d = retry_q;
        if (state_chg && (state_d == LT_TRAINERROR) && (retry_q != RW'(MAX_RETRY))) begin
            retry_d = retry_q + 1'b1;
        end else if (state_chg && (state_d == LT_ACTIVE)) begin
            retry_d = '0;
        end

        link_fail_d = link_fail_q;
        if ((state_q == LT_RESET) && !start_lt_i) begin
            link_fail_d = 1'b0;
        end
        if (state_chg && (state_d == LT_TRAINERROR) && (retry_d == RW'(MAX_RETRY))) begin
            link_fail_d = 1'b1;
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= LT_RESET;
            dwell_done_q <= 1'b0;
            hold_q       <= '0;
            retry_q      <= '0;
            link_fail_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            dwell_done_q <= dwell_done_d;
            hold_q       <= hold_d;
            retry_q      <= retry_d;
            link_fail_q  <= link_fail_d;
        end
    end

    SB_mux_sel_t sb_sel;
    MB_mux_sel_t mb_sel;

    always_comb begin
        sb_sel = SB_COMS;
        mb_sel = MB_Z;
        case (state_q)
            LT_RESET:    sb_sel = SB_DISABLED;
            LT_SBINIT:   sb_sel = SB_SBINIT;
            LT_MBINIT:   mb_sel = MB_MBINIT;
            LT_MBTRAIN:  mb_sel = MB_MBTRAIN;
            LT_LINKINIT: mb_sel = MB_COMS;
            LT_ACTIVE:   mb_sel = MB_COMS;
            LT_L1_L2:    mb_sel = MB_DISABLED;
            default:     mb_sel = MB_Z;
        endcase
    end

    assign sb_sel_o      = sb_sel;
    assign mb_sel_o      = mb_sel;
    assign state_o       = state_q;
    assign sbinit_en_o   = (state_q == LT_SBINIT);
    assign mbinit_en_o   = (state_q == LT_MBINIT);
    assign mbtrain_en_o  = (state_q == LT_MBTRAIN);
    assign linkinit_en_o = (state_q == LT_LINKINIT);
    assign link_up_o     = (state_q == LT_ACTIVE);
    assign link_fail_o   = link_fail_q;
    assign retry_cnt_o   = retry_q;

endmodule
